// File: rtl/jt12_timer_regs.sv
// CPU-side register front end for the jt12 timer pair: decodes port writes to 0x24-0x27
// into timer controls and returns the status byte {busy, 5'b0, flag_B, flag_A}.
module jt12_timer_regs #(
  parameter int BUSY_CYCLES = 32,
  parameter int BUSY_W      = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        cs_n,
  input  logic        wr_n,
  input  logic [1:0]  addr,
  input  logic [7:0]  din,
  input  logic        flag_A,
  input  logic        flag_B,
  output logic [7:0]  dout,
  output logic        busy,
  output logic [9:0]  value_A,
  output logic [7:0]  value_B,
  output logic        load_A,
  output logic        load_B,
  output logic        enable_irq_A,
  output logic        enable_irq_B,
  output logic        clr_flag_A,
  output logic        clr_flag_B,
  output logic [1:0]  csm
);

  localparam logic [BUSY_W-1:0] BUSY_LOAD = BUSY_W'(BUSY_CYCLES);

  logic              wr_q;
  logic              sel_part;
  logic [7:0]        sel_addr;
  logic [BUSY_W-1:0] busy_cnt;
  logic [BUSY_W-1:0] busy_cnt_nxt;
  logic              wr_act;
  logic              wr_ev;
  logic              data_we;

  assign wr_act  = ~cs_n & ~wr_n;
  assign wr_ev   = wr_act & ~wr_q;
  // part II and data writes to an unselected part still reload busy, but never touch registers
  assign data_we = wr_ev & addr[0] & ~sel_part & ~addr[1];

  // a data-write reload takes priority over a same-edge clk_en decrement
  always_comb begin
    busy_cnt_nxt = busy_cnt;
    if (wr_ev && addr[0])
      busy_cnt_nxt = BUSY_LOAD;
    else if (clk_en && busy_cnt != '0)
      busy_cnt_nxt = busy_cnt - BUSY_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q     <= 1'b0;
      busy_cnt <= '0;
      busy     <= 1'b0;
    end else begin
      wr_q     <= wr_act;
      busy_cnt <= busy_cnt_nxt;
      busy     <= (busy_cnt_nxt != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_addr     <= 8'h00;
      sel_part     <= 1'b0;
      value_A      <= 10'h000;
      value_B      <= 8'h00;
      load_A       <= 1'b0;
      load_B       <= 1'b0;
      enable_irq_A <= 1'b0;
      enable_irq_B <= 1'b0;
      clr_flag_A   <= 1'b0;
      clr_flag_B   <= 1'b0;
      csm          <= 2'b00;
    end else begin
      clr_flag_A <= 1'b0;
      clr_flag_B <= 1'b0;
      if (wr_ev && !addr[0]) begin
        sel_addr <= din;
        sel_part <= addr[1];
      end
      if (data_we) begin
        case (sel_addr)
          8'h24: value_A[9:2] <= din;
          8'h25: value_A[1:0] <= din[1:0];
          8'h26: value_B      <= din;
          8'h27: begin
            csm          <= din[7:6];
            clr_flag_B   <= din[5];
            clr_flag_A   <= din[4];
            enable_irq_B <= din[3];
            enable_irq_A <= din[2];
            load_B       <= din[1];
            load_A       <= din[0];
          end
          default: ;
        endcase
      end
    end
  end

  assign dout = {busy, 5'b00000, flag_B, flag_A};

endmodule

// File: tb/tb_jt12_timer_regs.sv
// Directed plus randomized bench for jt12_timer_regs against a register-map reference model.
module tb_jt12_timer_regs;

  localparam int BUSY = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_en = 1'b0;
  logic       cs_n = 1'b1;
  logic       wr_n = 1'b1;
  logic [1:0] addr = 2'b00;
  logic [7:0] din = 8'h00;
  logic       flag_A = 1'b0;
  logic       flag_B = 1'b0;
  logic [7:0] dout;
  logic       busy;
  logic [9:0] value_A;
  logic [7:0] value_B;
  logic       load_A, load_B, enable_irq_A, enable_irq_B, clr_flag_A, clr_flag_B;
  logic [1:0] csm;

  int total = 0;
  int bad = 0;

  jt12_timer_regs #(.BUSY_CYCLES(BUSY), .BUSY_W(6)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .cs_n(cs_n), .wr_n(wr_n), .addr(addr),
    .din(din), .flag_A(flag_A), .flag_B(flag_B), .dout(dout), .busy(busy),
    .value_A(value_A), .value_B(value_B), .load_A(load_A), .load_B(load_B),
    .enable_irq_A(enable_irq_A), .enable_irq_B(enable_irq_B),
    .clr_flag_A(clr_flag_A), .clr_flag_B(clr_flag_B), .csm(csm)
  );

  always #5 clk = ~clk;

  // reference model: the chip's register map as an array, busy as "ticks remaining"
  logic [7:0] m_reg [0:255];
  logic [7:0] m_sel;
  logic       m_part;
  logic       m_strobe_seen;
  int         m_rem;
  logic       m_clr_a, m_clr_b;

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_reg[i] = 8'h00;
    m_sel = 8'h00; m_part = 1'b0; m_strobe_seen = 1'b0;
    m_rem = 0; m_clr_a = 1'b0; m_clr_b = 1'b0;
  endtask

  task automatic model_step();
    logic act, ev;
    if (rst) begin
      model_reset();
      return;
    end
    act = !cs_n && !wr_n;
    ev = act && !m_strobe_seen;
    m_strobe_seen = act;
    m_clr_a = 1'b0; m_clr_b = 1'b0;
    if (ev && addr[0]) m_rem = BUSY;
    else if (clk_en && m_rem > 0) m_rem = m_rem - 1;
    if (ev && !addr[0]) begin
      m_sel = din; m_part = addr[1];
    end else if (ev && !m_part && !addr[1] && m_sel >= 8'h24 && m_sel <= 8'h27) begin
      m_reg[m_sel] = din;
      if (m_sel == 8'h27) begin
        m_clr_b = din[5]; m_clr_a = din[4];
      end
    end
  endtask

  function automatic logic [63:0] exp_vec();
    logic [7:0] r27;
    logic b;
    r27 = m_reg[8'h27];
    b = (m_rem != 0);
    return {29'b0, {b, 5'b00000, flag_B, flag_A}, b, m_reg[8'h24], m_reg[8'h25][1:0],
            m_reg[8'h26], r27[0], r27[1], r27[2], r27[3], m_clr_a, m_clr_b, r27[7:6]};
  endfunction

  function automatic logic [63:0] obs_vec();
    return {29'b0, dout, busy, value_A, value_B, load_A, load_B, enable_irq_A, enable_irq_B,
            clr_flag_A, clr_flag_B, csm};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic cs, input logic wr, input logic [1:0] a, input logic [7:0] d,
                     input logic ce);
    cs_n = cs; wr_n = wr; addr = a; din = d; clk_en = ce;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("model", obs_vec(), exp_vec());
  endtask

  task automatic idle(input int n, input logic ce);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 2'b00, 8'h00, ce);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cyc(1'b0, 1'b0, a, d, 1'b1);
    cyc(1'b1, 1'b1, a, d, 1'b1);
  endtask

  initial begin
    int pulses, busy_len, guard;
    model_reset();
    flag_A = 1'b1; flag_B = 1'b1;
    @(negedge clk);
    idle(3, 1'b1);
    check("rst_dout", 64'(dout), 64'h03);
    check("rst_outs", 64'({busy, value_A, value_B, load_A, load_B, enable_irq_A, enable_irq_B,
                           clr_flag_A, clr_flag_B, csm}), 64'h0);
    rst = 1'b0;
    idle(2, 1'b1);
    check("post_rst_dout", 64'(dout), 64'h03);
    check("post_rst_busy", 64'(busy), 64'h0);
    flag_A = 1'b0;

    // timer A value split over two registers
    wr(2'b00, 8'h24); wr(2'b01, 8'hAB);
    wr(2'b00, 8'h25); wr(2'b01, 8'hFE);
    check("value_A", 64'(value_A), 64'h2AE);
    idle(30, 1'b1);
    check("busy_tick31", 64'(busy), 64'h1);
    idle(1, 1'b1);
    check("busy_tick32", 64'(busy), 64'h0);

    // control register with flag-clear pulses
    wr(2'b00, 8'h27);
    cyc(1'b0, 1'b0, 2'b01, 8'h3F, 1'b1);
    check("ctl_pulse", 64'({clr_flag_A, clr_flag_B}), 64'h3);
    check("ctl_levels", 64'({load_A, load_B, enable_irq_A, enable_irq_B, csm}), 64'h3C);
    cyc(1'b1, 1'b1, 2'b01, 8'h3F, 1'b1);
    check("ctl_pulse_end", 64'({clr_flag_A, clr_flag_B}), 64'h0);
    cyc(1'b0, 1'b0, 2'b01, 8'hC0, 1'b1);
    check("ctl_csm", 64'({load_A, load_B, enable_irq_A, enable_irq_B, clr_flag_A, clr_flag_B, csm}),
          64'h03);
    cyc(1'b1, 1'b1, 2'b01, 8'hC0, 1'b1);

    // part II writes must not reach part I registers
    wr(2'b00, 8'h26); wr(2'b01, 8'h12);
    wr(2'b10, 8'h26); wr(2'b11, 8'h55);
    check("part2_valueB", 64'(value_B), 64'h12);
    check("part2_busy", 64'(busy), 64'h1);

    // held strobe gives one event; a second write reloads busy
    wr(2'b00, 8'h27);
    idle(40, 1'b1);
    pulses = 0; busy_len = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, 2'b01, 8'h10, 1'b1);
      pulses += int'(clr_flag_A); busy_len += int'(busy);
    end
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b1, 2'b01, 8'h10, 1'b1);
      pulses += int'(clr_flag_A); busy_len += int'(busy);
    end
    check("hold_one_pulse", 64'(pulses), 64'd1);
    cyc(1'b0, 1'b0, 2'b01, 8'h10, 1'b1);
    busy_len += int'(busy);
    guard = 0;
    while (busy && guard < 100) begin
      cyc(1'b1, 1'b1, 2'b01, 8'h10, 1'b1);
      busy_len += int'(busy);
      guard++;
    end
    check("busy_timeout", 64'(guard < 100), 64'h1);
    check("busy_reload_len", 64'(busy_len), 64'd52);

    // async reset mid-busy, no clock edge needed
    cyc(1'b0, 1'b0, 2'b01, 8'h0F, 1'b1);
    cyc(1'b1, 1'b1, 2'b01, 8'h0F, 1'b1);
    idle(16, 1'b1);
    check("pre_async_busy", 64'(busy), 64'h1);
    #1 rst = 1'b1;
    #1;
    model_reset();
    check("async_busy", 64'(busy), 64'h0);
    check("async_all", obs_vec(), exp_vec());
    @(negedge clk);

    // strobe already low when reset releases counts as an event on the first edge
    cyc(1'b0, 1'b0, 2'b01, 8'h77, 1'b1);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 2'b01, 8'h77, 1'b1);
    check("release_event_busy", 64'(busy), 64'h1);
    cyc(1'b1, 1'b1, 2'b01, 8'h77, 1'b1);

    // randomized traffic, biased toward the timer register addresses
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] a;
      logic [7:0] d;
      rst = ($urandom_range(0, 299) == 0);
      flag_A = 1'($urandom); flag_B = 1'($urandom);
      a = 2'($urandom);
      if (!a[0] && $urandom_range(0, 3) != 0) d = 8'h24 + 8'($urandom_range(0, 3));
      else d = 8'($urandom);
      if (a[1] && $urandom_range(0, 2) != 0) a[1] = 1'b0;
      cyc(1'($urandom_range(0, 7) == 0), 1'($urandom), a, d, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
